// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM state, owner encoding and width constants for mem_arbiter
package mem_arbiter_pkg;

    localparam int INST_W        = 32;
    localparam int MASK_W        = 8;
    localparam int WORD_OFFSET_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_IF) ? OWN_LSU : OWN_IF;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - 2-way grant logic; round-robin with MEM_ARB_RR_EN, LSU-first fixed priority otherwise
module mem_arb_grant
    import mem_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic   clk,
    input  logic   reset,
`endif
    input  logic   if_valid,
    input  logic   lsu_valid,
    input  logic   grant_en,
    output logic   grant_valid,
    output owner_t grant_owner
);

    assign grant_valid = grant_en && (if_valid || lsu_valid);

`ifdef MEM_ARB_RR_EN
    owner_t last_owner;

    always_comb begin
        grant_owner = OWN_IF;
        if (if_valid && lsu_valid) begin
            grant_owner = other_owner(last_owner);
        end else if (lsu_valid) begin
            grant_owner = OWN_LSU;
        end
    end

    // Starting from LSU makes IF the winner of the first contested grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= OWN_LSU;
        end else if (grant_valid) begin
            last_owner <= grant_owner;
        end
    end
`else
    assign grant_owner = lsu_valid ? OWN_LSU : OWN_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding IF/LSU memory arbiter; MEM_ARB_RR_EN selects round-robin grant
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [INST_W-1:0] if_inst,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'((1 << WORD_OFFSET_W) - 1);

    arb_state_t        state;
    owner_t            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;

    logic              grant_valid;
    owner_t            grant_owner;
    logic              accept;

    mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
        .clk         (clk),
        .reset       (reset),
`endif
        .if_valid    (if_req_valid),
        .lsu_valid   (lsu_req_valid),
        .grant_en    (state == IDLE),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Ready is the only combinational output: acceptance must happen in the grant cycle itself.
    assign accept        = grant_valid && !reset;
    assign if_req_ready  = accept && (grant_owner == OWN_IF);
    assign lsu_req_ready = accept && (grant_owner == OWN_LSU);

    assign busy          = (state != IDLE);
    assign mem_req_valid = (state == REQ);
    assign mem_addr      = addr_q & WORD_MASK;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            owner_q        <= OWN_IF;
            addr_q         <= '0;
            wen_q          <= 1'b0;
            wdata_q        <= '0;
            wmask_q        <= '0;
            if_resp_valid  <= 1'b0;
            lsu_resp_valid <= 1'b0;
            if_inst        <= '0;
            lsu_rdata      <= '0;
        end else begin
            if_resp_valid  <= 1'b0;
            lsu_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q <= grant_owner;
                        if (grant_owner == OWN_LSU) begin
                            addr_q  <= lsu_addr;
                            wen_q   <= lsu_wen;
                            wdata_q <= lsu_wdata;
                            wmask_q <= lsu_wmask;
                        end else begin
                            addr_q  <= if_addr;
                            wen_q   <= 1'b0;
                            wdata_q <= '0;
                            wmask_q <= '0;
                        end
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                        if (owner_q == OWN_IF) begin
                            if_resp_valid <= 1'b1;
                            if_inst       <= addr_q[2] ? mem_rdata[2*INST_W-1:INST_W]
                                                       : mem_rdata[INST_W-1:0];
                        end else begin
                            lsu_resp_valid <= 1'b1;
                            lsu_rdata      <= mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level reference model
module tb_mem_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req_valid, if_req_ready, if_resp_valid;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_inst;
    logic              lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
    logic [7:0]        lsu_wmask;
    logic              mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [7:0]        mem_wmask;
    logic              busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_inst(if_inst),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    bit check_en = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, described as a record plus progress flags.
    typedef struct {
        bit          is_lsu;
        logic [63:0] addr;
        bit          wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } txn_t;

    bit          m_busy = 0, m_sent = 0, m_if_pulse = 0, m_lsu_pulse = 0, m_lsu_is_read = 0;
    bit          m_if_last = 0;
    txn_t        m_txn;
    logic [31:0] m_inst;
    logic [63:0] m_rdata;
    int          dut_log[$];
    int          dut_cyc[$];

    function automatic int pick(input bit iv, input bit lv, input bit last_was_if);
`ifdef MEM_ARB_RR_EN
        if (iv && lv) return last_was_if ? 1 : 0;
`else
        if (iv && lv) return 1;
`endif
        if (lv) return 1;
        if (iv) return 0;
        return -1;
    endfunction

    initial begin
        int g;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_busy = 0; m_sent = 0; m_if_pulse = 0; m_lsu_pulse = 0; m_if_last = 0;
            end else begin
                m_if_pulse = 0;
                m_lsu_pulse = 0;
                if (m_busy && m_sent) begin
                    if (mem_resp_valid) begin
                        m_busy = 0;
                        if (m_txn.is_lsu) begin
                            m_lsu_pulse = 1;
                            m_lsu_is_read = !m_txn.wen;
                            m_rdata = mem_rdata;
                        end else begin
                            m_if_pulse = 1;
                            m_inst = m_txn.addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                        end
                    end
                end else if (m_busy) begin
                    if (mem_req_ready) m_sent = 1;
                end else begin
                    g = pick(if_req_valid, lsu_req_valid, m_if_last);
                    if (g >= 0) begin
                        m_busy = 1;
                        m_sent = 0;
                        m_if_last = (g == 0);
                        if (g == 1) m_txn = '{1'b1, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask};
                        else        m_txn = '{1'b0, if_addr, 1'b0, 64'h0, 8'h0};
                    end
                end
            end
        end
    end

    initial begin
        int exp_g;
        forever begin
            @(negedge clk);
            if (check_en) begin
                exp_g = (reset || m_busy) ? -1 : pick(if_req_valid, lsu_req_valid, m_if_last);
                chk("if_req_ready", if_req_ready, exp_g == 0);
                chk("lsu_req_ready", lsu_req_ready, exp_g == 1);
                chk("busy", busy, m_busy);
                chk("mem_req_valid", mem_req_valid, m_busy && !m_sent);
                if (m_busy) begin
                    chk("mem_addr", mem_addr, m_txn.addr & ~64'h7);
                    chk("mem_wen", mem_wen, m_txn.wen);
                    chk("mem_wdata", mem_wdata, m_txn.wdata);
                    chk("mem_wmask", mem_wmask, m_txn.wmask);
                end
                chk("if_resp_valid", if_resp_valid, m_if_pulse);
                chk("lsu_resp_valid", lsu_resp_valid, m_lsu_pulse);
                if (m_if_pulse) chk("if_inst", if_inst, m_inst);
                if (m_lsu_pulse && m_lsu_is_read) chk("lsu_rdata", lsu_rdata, m_rdata);
                if (if_req_ready)  begin dut_log.push_back(0); dut_cyc.push_back(cyc); end
                if (lsu_req_ready) begin dut_log.push_back(1); dut_cyc.push_back(cyc); end
            end
        end
    end

    // Stimulus helpers: a simple zero-wait memory and one-shot requesters.
    bit          auto_mem = 0, if_oneshot = 1, lsu_oneshot = 1;
    logic [63:0] rdata_cfg = '0;

    task automatic tick();
        bit hs, acc_if, acc_lsu;
        @(negedge clk); #1;
        hs      = mem_req_valid && mem_req_ready;
        acc_if  = if_req_valid && if_req_ready;
        acc_lsu = lsu_req_valid && lsu_req_ready;
        @(posedge clk); #1;
        if (auto_mem) begin
            mem_resp_valid = hs;
            mem_rdata      = rdata_cfg;
        end
        if (acc_if && if_oneshot)   if_req_valid = 0;
        if (acc_lsu && lsu_oneshot) lsu_req_valid = 0;
    endtask

    function automatic bit sig(input int sel);
        case (sel)
            0:       return if_resp_valid;
            1:       return lsu_resp_valid;
            2:       return mem_resp_valid;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_until(input int sel, input string name);
        int n = 0;
        while (!sig(sel) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        reset = 1;
        if_req_valid = 1; if_addr = '0;
        lsu_req_valid = 1; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
        @(posedge clk); #1;
        check_en = 1;
        chk("rst_if_req_ready", if_req_ready, 0);
        chk("rst_lsu_req_ready", lsu_req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
        chk("rst_if_inst", if_inst, 0);
        chk("rst_lsu_rdata", lsu_rdata, 0);
        if_req_valid = 0; lsu_req_valid = 0;
        tick();
        reset = 0;
        tick();

        // IF fetch, upper word, zero-wait memory
        auto_mem = 1; mem_req_ready = 1; rdata_cfg = 64'h11112222_33334444;
        if_addr = 64'h8000_0004; if_req_valid = 1;
        tick();
        chk("t1_mem_addr", mem_addr, 64'h8000_0000);
        chk("t1_mem_req_valid", mem_req_valid, 1);
        chk("t1_mem_wen", mem_wen, 0);
        tick();
        chk("t1_resp_early", if_resp_valid, 0);
        tick();
        chk("t1_resp_at_3", if_resp_valid, 1);
        chk("t1_if_inst", if_inst, 64'h1111_2222);
        tick();
        chk("t1_resp_one_cycle", if_resp_valid, 0);

        // IF fetch, lower word
        if_addr = 64'h8000_0010; if_req_valid = 1;
        wait_until(0, "t1b");
        chk("t1b_if_inst", if_inst, 64'h3333_4444);
        tick();

        // LSU write
        lsu_addr = 64'h8000_1008; lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F; lsu_wen = 1;
        lsu_req_valid = 1;
        tick();
        chk("t2_mem_wen", mem_wen, 1);
        chk("t2_mem_wmask", mem_wmask, 8'h0F);
        chk("t2_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
        chk("t2_mem_addr", mem_addr, 64'h8000_1008);
        wait_until(2, "t2_mem_resp");
        chk("t2_lsu_resp_not_yet", lsu_resp_valid, 0);
        tick();
        chk("t2_lsu_resp", lsu_resp_valid, 1);
        tick();
        chk("t2_lsu_resp_one_cycle", lsu_resp_valid, 0);

        // LSU read
        lsu_addr = 64'h8000_2000; lsu_wen = 0; lsu_wmask = 0; lsu_wdata = 0;
        rdata_cfg = 64'hCAFE_F00D_1234_5678; lsu_req_valid = 1;
        wait_until(1, "t3");
        chk("t3_lsu_rdata", lsu_rdata, 64'hCAFE_F00D_1234_5678);
        tick();

        // Memory stall, ignored early responses, back-to-back grant
        auto_mem = 0; mem_req_ready = 0; mem_resp_valid = 0;
        if_addr = 64'h8000_0123; if_req_valid = 1;
        tick();
        lsu_addr = 64'h8000_3000; lsu_req_valid = 1; if_addr = 64'h0;
        for (int i = 0; i < 5; i++) begin
            mem_resp_valid = (i == 2);
            #1;
            chk("t4_mem_req_valid", mem_req_valid, 1);
            chk("t4_mem_addr", mem_addr, 64'h8000_0120);
            chk("t4_if_req_ready", if_req_ready, 0);
            chk("t4_lsu_req_ready", lsu_req_ready, 0);
            chk("t4_busy", busy, 1);
            tick();
        end
        mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        mem_req_ready = 0; mem_resp_valid = 0;
        tick();
        tick();
        chk("t4_wait_busy", busy, 1);
        chk("t4_wait_no_resp", if_resp_valid, 0);
        mem_rdata = 64'h0123_4567_89AB_CDEF; mem_resp_valid = 1;
        tick();
        mem_resp_valid = 0;
        #1;
        chk("t4_if_resp", if_resp_valid, 1);
        chk("t4_if_inst", if_inst, 64'h89AB_CDEF);
        chk("t4_same_cycle_grant", lsu_req_ready, 1);
        auto_mem = 1; mem_req_ready = 1; rdata_cfg = 64'h5555_6666_7777_8888;
        wait_until(1, "t4_lsu");
        chk("t4_lsu_rdata", lsu_rdata, 64'h5555_6666_7777_8888);
        tick();

        // Contested grants from a fresh reset
        reset = 1;
        tick();
        reset = 0;
        dut_log.delete(); dut_cyc.delete();
        if_oneshot = 0; lsu_oneshot = 0;
        if_addr = 64'h8000_0040; lsu_addr = 64'h8000_0080;
        if_req_valid = 1; lsu_req_valid = 1;
        for (int n = 0; n < 40 && dut_log.size() < 4; n++) tick();
        if_req_valid = 0; lsu_req_valid = 0;
        if_oneshot = 1; lsu_oneshot = 1;
        if (dut_log.size() < 4) begin
            chk("t5_grant_count", dut_log.size(), 4);
        end else begin
`ifdef MEM_ARB_RR_EN
            chk("t5_grant0", dut_log[0], 0);
            chk("t5_grant1", dut_log[1], 1);
            chk("t5_grant2", dut_log[2], 0);
            chk("t5_grant3", dut_log[3], 1);
`else
            chk("t5_grant0", dut_log[0], 1);
            chk("t5_grant1", dut_log[1], 1);
            chk("t5_grant2", dut_log[2], 1);
            chk("t5_grant3", dut_log[3], 1);
`endif
            chk("t5_turnaround", dut_cyc[1] - dut_cyc[0], 3);
            chk("t5_turnaround2", dut_cyc[3] - dut_cyc[2], 3);
        end
        wait_until(3, "t5_drain");
        tick();

        // Reset while waiting for the memory response
        auto_mem = 0; mem_req_ready = 1; mem_resp_valid = 0;
        lsu_addr = 64'h8000_4000; lsu_wen = 1; lsu_wdata = 64'h77; lsu_wmask = 8'hFF;
        lsu_req_valid = 1;
        tick();
        tick();
        chk("t6_in_wait_busy", busy, 1);
        chk("t6_in_wait_mem_req_valid", mem_req_valid, 0);
        reset = 1;
        tick();
        reset = 0; mem_resp_valid = 1;
        tick();
        mem_resp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_lsu_resp", lsu_resp_valid, 0);
            chk("t6_if_resp", if_resp_valid, 0);
            chk("t6_busy", busy, 0);
            chk("t6_mem_wen", mem_wen, 0);
            chk("t6_mem_wmask", mem_wmask, 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

endmodule
